// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor.
// Build option: SERIAL_ADDSUB_EN adds the 'op' select (0 = subtract, 1 = add).
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Difference;
  logic             Borrow;
`ifdef SERIAL_ADDSUB_EN
  logic             op;

  modport master (output start, A, B, op, input busy, done, Difference, Borrow);
  modport slave  (input start, A, B, op, output busy, done, Difference, Borrow);
`else
  modport master (output start, A, B, input busy, done, Difference, Borrow);
  modport slave  (input start, A, B, output busy, done, Difference, Borrow);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Build option: SERIAL_ADDSUB_EN adds an add mode selected by bus.op.
// The done cycle also accepts a new start, giving one operation per WIDTH+1 cycles.
module serial_subtractor #(
  parameter int unsigned WIDTH = 32
) (
  input logic                clk,
  input logic                reset,
  serial_subtractor_if.slave bus
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state,    state_n;
  logic [WIDTH-1:0] sa,       sa_n;
  logic [WIDTH-1:0] sb,       sb_n;
  logic [WIDTH-1:0] sd,       sd_n;
  logic             bw,       bw_n;
  logic [CW-1:0]    cnt,      cnt_n;
  logic             busy_q,   busy_n;
  logic             done_q,   done_n;
  logic [WIDTH-1:0] diff_q,   diff_n;
  logic             borrow_q, borrow_n;
`ifdef SERIAL_ADDSUB_EN
  logic             op_q,     op_n;
`endif

  logic d;
  logic bw_step;
  logic x;

  // One-bit full subtract (or add) slice on the current LSBs
  always_comb begin
    x = sa[0] ^ sb[0];
    d = x ^ bw;
`ifdef SERIAL_ADDSUB_EN
    if (op_q) bw_step = (sa[0] & sb[0]) | (x & bw);
    else      bw_step = (~sa[0] & sb[0]) | (~x & bw);
`else
    bw_step = (~sa[0] & sb[0]) | (~x & bw);
`endif
  end

  // Next-state and next-register values
  always_comb begin
    state_n  = state;
    sa_n     = sa;
    sb_n     = sb;
    sd_n     = sd;
    bw_n     = bw;
    cnt_n    = cnt;
    busy_n   = busy_q;
    done_n   = 1'b0;
    diff_n   = diff_q;
    borrow_n = borrow_q;
`ifdef SERIAL_ADDSUB_EN
    op_n     = op_q;
`endif
    case (state)
      IDLE, DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
        if (bus.start) begin
          sa_n    = bus.A;
          sb_n    = bus.B;
          sd_n    = '0;
          bw_n    = 1'b0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = RUN;
`ifdef SERIAL_ADDSUB_EN
          op_n    = bus.op;
`endif
        end
      end
      RUN: begin
        sa_n  = {1'b0, sa[WIDTH-1:1]};
        sb_n  = {1'b0, sb[WIDTH-1:1]};
        sd_n  = {d, sd[WIDTH-1:1]};
        bw_n  = bw_step;
        cnt_n = cnt + CW'(1);
        if (cnt == LAST) begin
          cnt_n    = '0;
          busy_n   = 1'b0;
          done_n   = 1'b1;
          diff_n   = {d, sd[WIDTH-1:1]};
          borrow_n = bw_step;
          state_n  = DONE;
        end
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous reset clears everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      sd       <= '0;
      bw       <= 1'b0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_ADDSUB_EN
      op_q     <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      sa       <= sa_n;
      sb       <= sb_n;
      sd       <= sd_n;
      bw       <= bw_n;
      cnt      <= cnt_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      diff_q   <= diff_n;
      borrow_q <= borrow_n;
`ifdef SERIAL_ADDSUB_EN
      op_q     <= op_n;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.Difference = diff_q;
  assign bus.Borrow     = borrow_q;

endmodule
